block_nest_checker: RTL and testbench

- Streaming ASCII word checker for "begin"/"end" nesting, parametrised in counter depth, with an input valid qualifier and sticky error reporting.
- Consumes one character per accepted cycle; words are separated by space (8'h20).
- Reports whether the stream seen so far is balanced.
- Sits behind the character source in the P1 text-processing blocks.

---
 rtl/block_nest_checker_if.sv | 27 ++
 rtl/block_nest_checker.sv | 129 ++++++++++++
 tb/tb_block_nest_checker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/block_nest_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : block_nest_checker_if
// Brief    : Character stream and status bundle for block_nest_checker.
//            max_depth exists only when BLOCK_NEST_CHECKER_MAXDEPTH_EN is set.
// Revision : 1.0
// ============================================================================
interface block_nest_checker_if #(
  parameter int DEPTH_W = 8
);
  logic [7:0]         in;
  logic               in_valid;
  logic               result;
  logic [DEPTH_W-1:0] depth;
  logic               error;
  logic [1:0]         err_code;
`ifdef BLOCK_NEST_CHECKER_MAXDEPTH_EN
  logic [DEPTH_W-1:0] max_depth;

  modport master (output in, in_valid, input result, depth, error, err_code, max_depth);
  modport slave  (input in, in_valid, output result, depth, error, err_code, max_depth);
`else
  modport master (output in, in_valid, input result, depth, error, err_code);
  modport slave  (input in, in_valid, output result, depth, error, err_code);
`endif
endinterface
`default_nettype wire

// File: rtl/block_nest_checker.sv
`default_nettype none
// ============================================================================
// Module   : block_nest_checker
// Brief    : Streaming "begin"/"end" nesting checker with sticky errors.
//            Optional max-depth tracking via BLOCK_NEST_CHECKER_MAXDEPTH_EN.
// Revision : 1.0
// ============================================================================
module block_nest_checker #(
  parameter int DEPTH_W = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  block_nest_checker_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_B1    = 4'd1,
    S_B2    = 4'd2,
    S_B3    = 4'd3,
    S_B4    = 4'd4,
    S_BDONE = 4'd5,
    S_E1    = 4'd6,
    S_E2    = 4'd7,
    S_EDONE = 4'd8,
    S_OTHER = 4'd9
  } state_t;

  localparam logic [7:0]         c_delim = 8'h20;
  localparam logic [7:0]         c_b     = 8'h42;
  localparam logic [7:0]         c_e     = 8'h45;
  localparam logic [7:0]         c_g     = 8'h47;
  localparam logic [7:0]         c_i     = 8'h49;
  localparam logic [7:0]         c_n     = 8'h4E;
  localparam logic [7:0]         c_d     = 8'h44;
  localparam logic [DEPTH_W-1:0] c_max   = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W:0]   c_one   = {{DEPTH_W{1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic               r_error, w_error_nxt;
  logic [1:0]         r_code,  w_code_nxt;
  logic               r_result, w_result_nxt;
  logic [7:0]         w_ch;
  logic               w_delim;
  logic signed [DEPTH_W:0] w_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_depth  <= '0;
      r_error  <= 1'b0;
      r_code   <= 2'b00;
      r_result <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_depth  <= w_depth_nxt;
      r_error  <= w_error_nxt;
      r_code   <= w_code_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_error_nxt = r_error;
    w_code_nxt  = r_code;
    w_ch        = bus.in & 8'hDF;
    w_delim     = (bus.in == c_delim);
    if (bus.in_valid) begin
      if (w_delim) begin
        w_state_nxt = S_IDLE;
        // A keyword only takes effect when its delimiter arrives; the first error latches the code.
        if (r_state == S_BDONE) begin
          if (r_depth == c_max) begin
            w_error_nxt = 1'b1;
            if (!r_error) w_code_nxt = 2'b10;
          end else begin
            w_depth_nxt = r_depth + 1'b1;
          end
        end else if (r_state == S_EDONE) begin
          if (r_depth == '0) begin
            w_error_nxt = 1'b1;
            if (!r_error) w_code_nxt = 2'b01;
          end else begin
            w_depth_nxt = r_depth - 1'b1;
          end
        end
      end else begin
        unique case (r_state)
          S_IDLE:  w_state_nxt = (w_ch == c_b) ? S_B1 : (w_ch == c_e) ? S_E1 : S_OTHER;
          S_B1:    w_state_nxt = (w_ch == c_e) ? S_B2    : S_OTHER;
          S_B2:    w_state_nxt = (w_ch == c_g) ? S_B3    : S_OTHER;
          S_B3:    w_state_nxt = (w_ch == c_i) ? S_B4    : S_OTHER;
          S_B4:    w_state_nxt = (w_ch == c_n) ? S_BDONE : S_OTHER;
          S_E1:    w_state_nxt = (w_ch == c_n) ? S_E2    : S_OTHER;
          S_E2:    w_state_nxt = (w_ch == c_d) ? S_EDONE : S_OTHER;
          default: w_state_nxt = S_OTHER;
        endcase
      end
    end
    // A completed "end" awaiting its delimiter already counts against the balance.
    w_eff = (w_state_nxt == S_EDONE) ? $signed({1'b0, w_depth_nxt} - c_one)
                                     : $signed({1'b0, w_depth_nxt});
    w_result_nxt = !w_error_nxt && (w_eff == '0);
  end

  assign bus.depth    = r_depth;
  assign bus.error    = r_error;
  assign bus.err_code = r_code;
  assign bus.result   = r_result;

`ifdef BLOCK_NEST_CHECKER_MAXDEPTH_EN
  logic [DEPTH_W-1:0] r_max_depth;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_depth <= '0;
    end else if (w_depth_nxt > r_max_depth) begin
      r_max_depth <= w_depth_nxt;
    end
  end

  assign bus.max_depth = r_max_depth;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_nest_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_nest_checker
// Brief    : Directed self-checking bench for block_nest_checker (DEPTH_W 8 and 2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tb_in = 8'h00;
  logic       tb_valid = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  block_nest_checker_if #(.DEPTH_W(8)) bus8 ();
  block_nest_checker_if #(.DEPTH_W(2)) bus2 ();

  assign bus8.in       = tb_in;
  assign bus8.in_valid = tb_valid;
  assign bus2.in       = tb_in;
  assign bus2.in_valid = tb_valid;

  block_nest_checker #(.DEPTH_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  block_nest_checker #(.DEPTH_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input byte ch);
    tb_in    = ch;
    tb_valid = 1'b1;
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic apply_reset();
    tb_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string tail;
    // Test 1: reset held while a valid character is already presented
    tb_in    = "a";
    tb_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t1_rst_result", bus8.result, 1);
    check("t1_rst_depth", bus8.depth, 0);
    check("t1_rst_error", bus8.error, 0);
    check("t1_rst_code", bus8.err_code, 0);
    reset = 1'b1;
    send_str("a BEgIn");
    send(" ");
    check("t1_begin_result", bus8.result, 0);
    check("t1_begin_depth", bus8.depth, 1);
    send_str("End");
    check("t1_endc_d_result", bus8.result, 1);
    send("c");
    check("t1_endc_c_result", bus8.result, 0);
    send_str(" end");
    check("t1_end_d_result", bus8.result, 1);
    send(" ");
    check("t1_end_sp_depth", bus8.depth, 0);
    check("t1_end_sp_result", bus8.result, 1);
    send_str("end");
    check("t1_end2_d_result", bus8.result, 0);
    send(" ");
    check("t1_uf_error", bus8.error, 1);
    check("t1_uf_code", bus8.err_code, 2'b01);
    check("t1_uf_depth", bus8.depth, 0);
    tail = "bEGin ";
    for (int i = 0; i < tail.len(); i++) begin
      send(tail[i]);
      check("t1_tail_result", bus8.result, 0);
    end
    check("t1_tail_depth", bus8.depth, 1);
    check("t1_tail_code", bus8.err_code, 2'b01);

    // Test 2: idle cycles interleaved with garbage on the data lines
    apply_reset();
    begin
      string s2;
      int    exp_d [4];
      int    k;
      s2 = "begin begin end end ";
      exp_d = '{1, 2, 1, 0};
      k = 0;
      for (int i = 0; i < s2.len(); i++) begin
        send(s2[i]);
        tb_in = " ";
        @(posedge clk);
        #1;
        if (s2[i] == " ") begin
          check("t2_depth", bus8.depth, exp_d[k]);
          k++;
        end
      end
      check("t2_result", bus8.result, 1);
      check("t2_error", bus8.error, 0);
    end

    // Test 3: overflow on the 2-bit instance
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      send_str("begin ");
      check("t3_depth", bus2.depth, (i < 3) ? i : 3);
      check("t3_error", bus2.error, (i == 4) ? 1 : 0);
    end
    check("t3_code", bus2.err_code, 2'b10);
    check("t3_result", bus2.result, 0);

    // Test 4: words with trailing letters and an unterminated begin
    apply_reset();
    send_str("beginx endy");
    check("t4_endy_result", bus8.result, 1);
    send_str(" begin");
    check("t4_depth", bus8.depth, 0);
    check("t4_result", bus8.result, 1);
    check("t4_error", bus8.error, 0);

    // Test 5: asynchronous reset in the middle of a word
    apply_reset();
    send_str("end begin ");
    check("t5_pre_code", bus8.err_code, 2'b01);
    check("t5_pre_depth", bus8.depth, 1);
    send_str("beg");
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_depth", bus8.depth, 0);
    check("t5_async_result", bus8.result, 1);
    check("t5_async_error", bus8.error, 0);
    check("t5_async_code", bus8.err_code, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_str("end ");
    check("t5_uf_error", bus8.error, 1);
    check("t5_uf_code", bus8.err_code, 2'b01);

`ifdef BLOCK_NEST_CHECKER_MAXDEPTH_EN
    // Test 6: high-water mark of committed depth
    send_str("begin begin ");
    apply_reset();
    check("t6_rst_max", bus8.max_depth, 0);
    send_str("begin begin begin end end begin ");
    check("t6_max", bus8.max_depth, 3);
    check("t6_depth", bus8.depth, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
